// File: rtl/dmem_mmio.sv
// Data-memory responder for the single-cycle RV32 core: word RAM plus an MMIO page (GPIO, auto-reload timer).
// Define DMEM_MMIO_TIMER_EN to build the timer; otherwise its registers read 0 and TimerIrq is tied low.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic [31:0]           Addr,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  input  logic [GPIO_WIDTH-1:0] GpioIn,
  output logic [GPIO_WIDTH-1:0] GpioOut,
  output logic                  TimerIrq
);

  localparam int AW = $clog2(RAM_WORDS);

  localparam logic [2:0] SEL_GPIO_OUT = 3'd0;
  localparam logic [2:0] SEL_GPIO_IN  = 3'd1;
  localparam logic [2:0] SEL_TCOUNT   = 3'd2;
  localparam logic [2:0] SEL_TCMP     = 3'd3;
  localparam logic [2:0] SEL_TCTRL    = 3'd4;

  logic          is_mmio;
  logic [2:0]    sel;
  logic [AW-1:0] ram_idx;
  logic          wr_ram;
  logic          wr_mmio;
  logic          unused_addr;

  assign is_mmio = Addr[31];
  assign sel     = Addr[4:2];
  assign ram_idx = Addr[AW+1:2];
  // RAM writes are suppressed during reset; MMIO writes lose to the reset branch below.
  assign wr_ram  = MemWrite && !is_mmio && !reset;
  assign wr_mmio = MemWrite && is_mmio;
  assign unused_addr = ^{Addr[30:AW+2], Addr[1:0]};

  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= WriteData;
  end

  logic [GPIO_WIDTH-1:0] gpio_out;
  logic [GPIO_WIDTH-1:0] gpio_s1;
  logic [GPIO_WIDTH-1:0] gpio_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out <= '0;
      gpio_s1  <= '0;
      gpio_s2  <= '0;
    end else begin
      gpio_s1 <= GpioIn;
      gpio_s2 <= gpio_s1;
      if (wr_mmio && sel == SEL_GPIO_OUT) gpio_out <= WriteData[GPIO_WIDTH-1:0];
    end
  end

  assign GpioOut = gpio_out;

  logic [31:0] tcount_rd;
  logic [31:0] tcmp_rd;
  logic [31:0] tctrl_rd;

`ifdef DMEM_MMIO_TIMER_EN
  logic [31:0] tcount;
  logic [31:0] tcmp;
  logic        t_en;
  logic        t_ie;
  logic        t_pend;
  logic        wr_tcount;
  logic        wr_tcmp;
  logic        wr_tctrl;
  logic        tmatch;

  assign wr_tcount = wr_mmio && sel == SEL_TCOUNT;
  assign wr_tcmp   = wr_mmio && sel == SEL_TCMP;
  assign wr_tctrl  = wr_mmio && sel == SEL_TCTRL;
  // A CPU write to TCOUNT pre-empts this edge's reload and its PEND set.
  assign tmatch    = t_en && (tcount == tcmp) && !wr_tcount;

  always_ff @(posedge clk) begin
    if (reset) begin
      tcount <= '0;
      tcmp   <= '0;
      t_en   <= 1'b0;
      t_ie   <= 1'b0;
      t_pend <= 1'b0;
    end else begin
      if (wr_tcount)   tcount <= WriteData;
      else if (tmatch) tcount <= '0;
      else if (t_en)   tcount <= tcount + 32'd1;
      if (wr_tcmp) tcmp <= WriteData;
      if (wr_tctrl) begin
        t_en <= WriteData[0];
        t_ie <= WriteData[1];
      end
      // Match-set wins over a same-edge write-1-to-clear.
      if (tmatch)                         t_pend <= 1'b1;
      else if (wr_tctrl && WriteData[2]) t_pend <= 1'b0;
    end
  end

  assign tcount_rd = tcount;
  assign tcmp_rd   = tcmp;
  assign tctrl_rd  = {29'd0, t_pend, t_ie, t_en};
  assign TimerIrq  = t_pend & t_ie;
`else
  assign tcount_rd = '0;
  assign tcmp_rd   = '0;
  assign tctrl_rd  = '0;
  assign TimerIrq  = 1'b0;
`endif

  logic [31:0] gpio_out_rd;
  logic [31:0] gpio_in_rd;

  always_comb begin
    gpio_out_rd                   = '0;
    gpio_in_rd                    = '0;
    gpio_out_rd[GPIO_WIDTH-1:0]   = gpio_out;
    gpio_in_rd[GPIO_WIDTH-1:0]    = gpio_s2;
  end

  always_comb begin
    ReadData = '0;
    if (!is_mmio) begin
      ReadData = ram[ram_idx];
    end else begin
      unique case (sel)
        SEL_GPIO_OUT: ReadData = gpio_out_rd;
        SEL_GPIO_IN:  ReadData = gpio_in_rd;
        SEL_TCOUNT:   ReadData = tcount_rd;
        SEL_TCMP:     ReadData = tcmp_rd;
        SEL_TCTRL:    ReadData = tctrl_rd;
        default:      ReadData = '0;
      endcase
    end
  end

endmodule
